// File: rtl/rx_os_pkg.sv
// Shared types and helpers for the Rx ordered-set consensus tracker.
package rx_os_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // capturedLane is always this wide, independent of NUM_LANES (up to 32 lanes).
  localparam int LANE_IDX_W = 5;

  // A programmed threshold of zero behaves like one.
  function automatic logic [31:0] eff_threshold(input logic [31:0] req);
    return (req == 32'd0) ? 32'd1 : req;
  endfunction

endpackage

// File: rtl/rx_os_lane_counter.sv
// Per-lane masked ordered-set compare with saturating consecutive-match counter.
// Optional macro RX_OS_IDENTICAL_EN: also require each set to equal the previous
// valid set on this lane (under matchMask) before it counts.
module rx_os_lane_counter
  import rx_os_pkg::*;
#(
  parameter int OS_WIDTH  = 128,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic                 i_active,
  input  logic [OS_WIDTH-1:0]  i_os,
  input  logic [OS_WIDTH-1:0]  i_expected,
  input  logic [OS_WIDTH-1:0]  i_mask,
  input  logic [CNT_WIDTH-1:0] i_threshold,
  output logic                 o_matched,
  output logic                 o_matched_next
);

  logic                 w_exp_match;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_next;
  logic                 r_matched;

  assign w_exp_match = ((i_os ^ i_expected) & i_mask) == '0;

`ifdef RX_OS_IDENTICAL_EN
  logic [OS_WIDTH-1:0] r_prev_os;
  logic                r_have_prev;
  logic                w_same;

  assign w_same = ((i_os ^ r_prev_os) & i_mask) == '0;

  // Next count: first set after start only seeds; a change of content restarts at 1.
  always_comb begin
    w_count_next = r_count;
    if (!i_active) begin
      w_count_next = '0;
    end else if (i_valid) begin
      if (!w_exp_match)
        w_count_next = '0;
      else if (!r_have_prev || !w_same)
        w_count_next = CNT_WIDTH'(1);
      else
        w_count_next = (r_count >= i_threshold) ? i_threshold : r_count + CNT_WIDTH'(1);
    end
  end

  // Remember the last valid set seen on this lane within the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_os   <= '0;
      r_have_prev <= 1'b0;
    end else if (i_clear) begin
      r_prev_os   <= '0;
      r_have_prev <= 1'b0;
    end else if (i_enable && i_valid && i_active) begin
      r_prev_os   <= i_os;
      r_have_prev <= 1'b1;
    end
  end
`else
  // Next count: increment on a masked match, saturating at threshold; mismatch clears.
  always_comb begin
    w_count_next = r_count;
    if (!i_active)
      w_count_next = '0;
    else if (i_valid)
      w_count_next = !w_exp_match ? '0 :
                     (r_count >= i_threshold) ? i_threshold : r_count + CNT_WIDTH'(1);
  end
`endif

  // Counter and matched flag update together while the window is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_matched <= 1'b0;
    end else if (i_clear) begin
      r_count   <= '0;
      r_matched <= 1'b0;
    end else if (i_enable) begin
      r_count   <= w_count_next;
      r_matched <= (w_count_next >= i_threshold);
    end
  end

  assign o_matched      = r_matched;
  assign o_matched_next = i_enable && (w_count_next >= i_threshold);

endmodule

// File: rtl/rx_os_consensus_tracker.sv
// Rx LTSSM ordered-set qualifier: per-lane consecutive-match counting, any/all
// lane consensus, timeout window and capture of the first qualifying lane.
// Optional macro RX_OS_IDENTICAL_EN (see rx_os_lane_counter).
//
// state | meaning
// IDLE  | waiting for start; results from the last window held
// COUNT | window open, lanes counting, timer running
// DONE  | one-cycle done pulse, results valid
module rx_os_consensus_tracker
  import rx_os_pkg::*;
#(
  parameter int NUM_LANES   = 16,
  parameter int OS_WIDTH    = 128,
  parameter int CNT_WIDTH   = 5,
  parameter int TIMER_WIDTH = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_LANES*OS_WIDTH-1:0] orderedSets,
  input  logic                          validOrderedSets,
  input  logic [NUM_LANES-1:0]          laneMask,
  input  logic [OS_WIDTH-1:0]           expectedOs,
  input  logic [OS_WIDTH-1:0]           matchMask,
  input  logic [CNT_WIDTH-1:0]          requiredCount,
  input  logic [TIMER_WIDTH-1:0]        timeoutCycles,
  input  logic                          anyLaneMode,
  output logic                          busy,
  output logic                          done,
  output logic                          success,
  output logic                          timeOut,
  output logic [NUM_LANES-1:0]          laneMatched,
  output logic [OS_WIDTH-1:0]           capturedOs,
  output logic [LANE_IDX_W-1:0]         capturedLane
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [TIMER_WIDTH-1:0]  r_timer;
  logic [CNT_WIDTH-1:0]    w_thr;
  logic                    w_count_en;
  logic [NUM_LANES-1:0]    w_lane_matched;
  logic [NUM_LANES-1:0]    w_lane_hit;
  logic [NUM_LANES-1:0]    w_active_matched;
  logic                    w_met;
  logic                    w_expired;
  logic                    r_success;
  logic                    r_timeout;
  logic                    r_captured;
  logic [OS_WIDTH-1:0]     r_cap_os;
  logic [LANE_IDX_W-1:0]   r_cap_lane;
  logic                    w_cap_valid;
  logic [OS_WIDTH-1:0]     w_cap_os;
  logic [LANE_IDX_W-1:0]   w_cap_idx;

  assign w_thr      = CNT_WIDTH'(eff_threshold(32'(requiredCount)));
  assign w_count_en = (r_state == COUNT);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rx_os_lane_counter #(
      .OS_WIDTH  (OS_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_lane (
      .clk            (clk),
      .reset          (reset),
      .i_clear        (start),
      .i_enable       (w_count_en),
      .i_valid        (validOrderedSets),
      .i_active       (laneMask[g]),
      .i_os           (orderedSets[g*OS_WIDTH +: OS_WIDTH]),
      .i_expected     (expectedOs),
      .i_mask         (matchMask),
      .i_threshold    (w_thr),
      .o_matched      (w_lane_matched[g]),
      .o_matched_next (w_lane_hit[g])
    );
  end

  assign w_active_matched = w_lane_matched & laneMask;
  assign w_met = anyLaneMode ? (|w_active_matched)
                             : ((laneMask != '0) && (w_active_matched == laneMask));
  assign w_expired = (timeoutCycles != '0) && (r_timer == '0);

  // Lowest-index lane reaching threshold this cycle wins the capture.
  always_comb begin
    w_cap_valid = 1'b0;
    w_cap_idx   = '0;
    w_cap_os    = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_lane_hit[i]) begin
        w_cap_valid = 1'b1;
        w_cap_idx   = LANE_IDX_W'(i);
        w_cap_os    = orderedSets[i*OS_WIDTH +: OS_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and Moore outputs; start restarts from any state, so an
  // aborted window never reaches DONE.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = COUNT;
      end
      COUNT: begin
        busy = 1'b1;
        if (start)                   w_state_next = COUNT;
        else if (w_met || w_expired) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = start ? COUNT : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Window budget: loaded on start, counts down to zero while counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_timer <= '0;
    else if (start)
      r_timer <= timeoutCycles;
    else if (w_count_en && (timeoutCycles != '0) && (r_timer != '0))
      r_timer <= r_timer - TIMER_WIDTH'(1);
  end

  // Held results; success takes priority when both end conditions coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_success <= 1'b0;
      r_timeout <= 1'b0;
    end else if (start) begin
      r_success <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_count_en && w_met) begin
      r_success <= 1'b1;
    end else if (w_count_en && w_expired) begin
      r_timeout <= 1'b1;
    end
  end

  // One-shot capture of the first lane to qualify in the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_captured <= 1'b0;
      r_cap_os   <= '0;
      r_cap_lane <= '0;
    end else if (start) begin
      r_captured <= 1'b0;
      r_cap_os   <= '0;
      r_cap_lane <= '0;
    end else if (!r_captured && w_cap_valid) begin
      r_captured <= 1'b1;
      r_cap_os   <= w_cap_os;
      r_cap_lane <= w_cap_idx;
    end
  end

  assign success      = r_success;
  assign timeOut      = r_timeout;
  assign laneMatched  = w_lane_matched;
  assign capturedOs   = r_cap_os;
  assign capturedLane = r_cap_lane;

endmodule

// File: tb/tb_rx_os_consensus_tracker.sv
// Self-checking bench for rx_os_consensus_tracker (4 lanes, 32-bit sets).
module tb_rx_os_consensus_tracker;

  localparam int NL = 4;
  localparam int W  = 32;
  localparam int CW = 5;
  localparam int TW = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [NL*W-1:0] orderedSets;
  logic            validOrderedSets;
  logic [NL-1:0]   laneMask;
  logic [W-1:0]    expectedOs;
  logic [W-1:0]    matchMask;
  logic [CW-1:0]   requiredCount;
  logic [TW-1:0]   timeoutCycles;
  logic            anyLaneMode;
  logic            busy, done, success, timeOut;
  logic [NL-1:0]   laneMatched;
  logic [W-1:0]    capturedOs;
  logic [4:0]      capturedLane;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_os_consensus_tracker #(
    .NUM_LANES(NL), .OS_WIDTH(W), .CNT_WIDTH(CW), .TIMER_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .orderedSets(orderedSets),
    .validOrderedSets(validOrderedSets), .laneMask(laneMask), .expectedOs(expectedOs),
    .matchMask(matchMask), .requiredCount(requiredCount), .timeoutCycles(timeoutCycles),
    .anyLaneMode(anyLaneMode), .busy(busy), .done(done), .success(success),
    .timeOut(timeOut), .laneMatched(laneMatched), .capturedOs(capturedOs),
    .capturedLane(capturedLane)
  );

  // Reference model: window open flag, edges elapsed, per-lane run lengths.
  bit            m_open, m_done, m_succ, m_to, m_capf;
  int            m_elapsed, m_T;
  int            m_run [NL];
  logic [NL-1:0] m_matched;
  logic [W-1:0]  m_capos;
  int            m_caplane;
  logic [NL*W-1:0] sets_log [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_done = 0; m_succ = 0; m_to = 0; m_capf = 0;
    m_elapsed = 0; m_T = 0; m_matched = '0; m_capos = '0; m_caplane = 0;
    for (int i = 0; i < NL; i++) m_run[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic model_step();
    int  thr;
    bit  met, expired;
    logic [W-1:0] os;
    if (reset) begin
      model_reset();
      return;
    end
    thr = (requiredCount == 0) ? 1 : int'(requiredCount);
    if (start) begin
      model_reset();
      m_open = 1;
      m_T    = int'(timeoutCycles);
      return;
    end
    if (m_done) begin
      m_done = 0;
    end else if (m_open) begin
      met = anyLaneMode ? (|(m_matched & laneMask))
                        : (laneMask != 0 && (m_matched & laneMask) == laneMask);
      expired = (m_T != 0) && (m_elapsed >= m_T);
      for (int i = 0; i < NL; i++) begin
        os = orderedSets[i*W +: W];
        if (!laneMask[i]) m_run[i] = 0;
        else if (validOrderedSets)
          m_run[i] = (((os ^ expectedOs) & matchMask) == 0) ? m_run[i] + 1 : 0;
        if (m_run[i] > thr) m_run[i] = thr;
        m_matched[i] = (m_run[i] >= thr);
      end
      if (!m_capf) begin
        for (int i = 0; i < NL; i++) begin
          if (!m_capf && m_matched[i]) begin
            m_capf    = 1;
            m_caplane = i;
            m_capos   = orderedSets[i*W +: W];
          end
        end
      end
      m_elapsed++;
      if (met) begin
        m_open = 0; m_done = 1; m_succ = 1;
      end else if (expired) begin
        m_open = 0; m_done = 1; m_to = 1;
      end
    end
  endtask

  task automatic check_model();
    chk("busy", busy, m_open);
    chk("done", done, m_done);
    chk("success", success, m_succ);
    chk("timeOut", timeOut, m_to);
    chk("laneMatched", laneMatched, m_matched);
    chk("capturedOs", capturedOs, m_capos);
    chk("capturedLane", capturedLane, m_caplane);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    @(negedge clk);
  endtask

  // Drive one ordered set per lane; lanes with good=0 get a masked bit flipped.
  task automatic drive(input bit valid, input logic [NL-1:0] good);
    logic [W-1:0] r, os, flip;
    validOrderedSets = valid;
    for (int i = 0; i < NL; i++) begin
      r  = $urandom();
      os = (expectedOs & matchMask) | (r & ~matchMask);
      if (!good[i]) begin
        flip = $urandom() & matchMask;
        if (flip == 0) flip = matchMask & (~matchMask + 1);
        os = os ^ flip;
      end
      orderedSets[i*W +: W] = os;
    end
  endtask

  // Start a window and feed valid sets until done; n = sets fed.
  task automatic run_win(input logic [NL-1:0] good, input int bad_lane, input int bad_at,
                         input int limit, output int n);
    logic [NL-1:0] g;
    sets_log.delete();
    n = 0;
    drive(1'b1, good);
    start = 1'b1;
    step();
    start = 1'b0;
    while (n < limit) begin
      g = good;
      if (bad_at != 0 && n + 1 == bad_at) g[bad_lane] = 1'b0;
      drive(1'b1, g);
      sets_log.push_back(orderedSets);
      step();
      n++;
      if (done) break;
    end
  endtask

  initial begin
    int n, saw;
    logic [NL*W-1:0] tmp;
    logic [NL-1:0]   gv;
    model_reset();
    reset = 1'b1; start = 1'b0; validOrderedSets = 1'b0; orderedSets = '0;
    laneMask = 4'hF; expectedOs = 32'hA5C3_1E78; matchMask = 32'hFFFF_0F0F;
    requiredCount = 5'd8; timeoutCycles = 24'd1000; anyLaneMode = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lanematched", laneMatched, 0);
    chk("rst_capturedLane", capturedLane, 0);
    reset = 1'b0;
    step();

    // all lanes match 8 times
    run_win(4'hF, 0, 0, 200, n);
    chk("t1_latency", n, 9);
    chk("t1_success", success, 1);
    chk("t1_laneMatched", laneMatched, 4'hF);
    chk("t1_capturedLane", capturedLane, 0);

    // lane 2 corrupts set 5
    run_win(4'hF, 2, 5, 200, n);
    chk("t2_latency", n, 14);
    chk("t2_success", success, 1);
    chk("t2_capturedLane", capturedLane, 0);

    // any mode, only lane 3 matches
    anyLaneMode = 1'b1;
    run_win(4'b1000, 0, 0, 200, n);
    chk("t3_latency", n, 9);
    chk("t3_capturedLane", capturedLane, 3);
    tmp = sets_log[7];
    chk("t3_capturedOs", capturedOs, tmp[3*W +: W]);

    // no matches, 50-cycle budget
    anyLaneMode = 1'b0; timeoutCycles = 24'd50;
    run_win(4'h0, 0, 0, 200, n);
    chk("t4_latency", n, 51);
    chk("t4_timeOut", timeOut, 1);
    chk("t4_success", success, 0);

    // threshold reached exactly on expiry
    timeoutCycles = 24'd8;
    run_win(4'hF, 0, 0, 200, n);
    chk("t5_latency", n, 9);
    chk("t5_success", success, 1);
    chk("t5_timeOut", timeOut, 0);

    // empty lane mask in all mode
    laneMask = 4'h0; timeoutCycles = 24'd20;
    run_win(4'hF, 0, 0, 200, n);
    chk("t6_latency", n, 21);
    chk("t6_timeOut", timeOut, 1);
    chk("t6_success", success, 0);
    chk("t6_laneMatched", laneMatched, 0);

    // threshold 0 behaves as 1
    laneMask = 4'hF; timeoutCycles = 24'd1000; requiredCount = 5'd0;
    run_win(4'hF, 0, 0, 200, n);
    chk("t7_req0_latency", n, 2);

    // restart mid-window
    requiredCount = 5'd8;
    drive(1'b1, 4'hF);
    start = 1'b1; step(); start = 1'b0;
    saw = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'hF);
      step();
      if (done) saw++;
    end
    run_win(4'hF, 0, 0, 200, n);
    chk("t8_no_done_aborted", saw, 0);
    chk("t8_latency", n, 9);

    // async reset mid-COUNT
    requiredCount = 5'd3;
    drive(1'b1, 4'hF);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'hF);
      step();
    end
    chk("t9_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t9_busy", busy, 0);
    chk("t9_success", success, 0);
    chk("t9_laneMatched", laneMatched, 0);
    chk("t9_capturedOs", capturedOs, 0);
    model_reset();
    step();
    reset = 1'b0;
    step();

    // randomized windows
    for (int w = 0; w < 40; w++) begin
      laneMask      = NL'($urandom());
      anyLaneMode   = 1'($urandom());
      requiredCount = CW'($urandom_range(0, 6));
      timeoutCycles = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(3, 40));
      expectedOs    = $urandom();
      matchMask     = $urandom() | 32'h1;
      drive(1'b1, 4'hF);
      start = 1'b1; step(); start = 1'b0;
      for (int k = 0; k < 45; k++) begin
        for (int i = 0; i < NL; i++) gv[i] = ($urandom_range(0, 99) < 85);
        drive($urandom_range(0, 3) != 0, gv);
        start = ($urandom_range(0, 59) == 0);
        step();
        start = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
